// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer: op codes, FSM states and memory geometry.
package mem_access_unit_pkg;

    localparam int unsigned DEFAULT_N          = 2097152;
    localparam int unsigned DEFAULT_DATA_LIMIT = DEFAULT_N / 2;

    localparam logic [1:0] OP_ILLEGAL = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_LOAD2   = 2'd2;
    localparam logic [1:0] OP_STORE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Memory read code for an op: 1 = single word, 2 = word pair, 0 = no read.
    function automatic logic [1:0] read_code(input logic [1:0] op);
        case (op)
            OP_LOAD:  return 2'd1;
            OP_LOAD2: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshakes plus the data-memory port of the load/store sequencer.
interface mem_access_unit_if;

    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [31:0]        req_addr1;
    logic [31:0]        req_addr2;
    logic [31:0]        req_wdata;

    logic               rsp_valid;
    logic               rsp_ready;
    logic signed [31:0] rsp_data1;
    logic signed [31:0] rsp_data2;
    logic               rsp_fault;

    logic [31:0]        mem_address1;
    logic [31:0]        mem_address2;
    logic [31:0]        mem_write_data;
    logic [1:0]         mem_read;
    logic               mem_write;
    logic               mem_en;
    logic signed [31:0] mem_data1;
    logic signed [31:0] mem_data2;

    modport master (
        output req_valid, req_op, req_addr1, req_addr2, req_wdata, rsp_ready,
               mem_data1, mem_data2,
        input  req_ready, rsp_valid, rsp_data1, rsp_data2, rsp_fault,
               mem_address1, mem_address2, mem_write_data, mem_read, mem_write, mem_en
    );

    modport slave (
        input  req_valid, req_op, req_addr1, req_addr2, req_wdata, rsp_ready,
               mem_data1, mem_data2,
        output req_ready, rsp_valid, rsp_data1, rsp_data2, rsp_fault,
               mem_address1, mem_address2, mem_write_data, mem_read, mem_write, mem_en
    );

endinterface

// File: rtl/mem_addr_check.sv
// Combinational legality check: flags illegal ops and addresses outside the data region.
module mem_addr_check
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_LIMIT = DEFAULT_DATA_LIMIT
) (
    input  logic [1:0]  op,
    input  logic [31:0] addr1,
    input  logic [31:0] addr2,
    output logic        fault
);

    localparam logic [31:0] LIMIT = 32'(DATA_LIMIT);

    always_comb begin
        fault = 1'b0;
        if (op == OP_ILLEGAL) begin
            fault = 1'b1;
        end
        if (addr1 >= LIMIT) begin
            fault = 1'b1;
        end
        // The second address only matters for a pair load.
        if ((op == OP_LOAD2) && (addr2 >= LIMIT)) begin
            fault = 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request at a time, range-checked, across a one-cycle registered-read memory.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned DATA_LIMIT = N / 2
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    state_t             state_reg;
    logic [1:0]         op_reg;
    logic               fault_reg;
    logic               req_ready_reg;
    logic               rsp_valid_reg;
    logic               rsp_fault_reg;
    logic signed [31:0] rsp_data1_reg;
    logic signed [31:0] rsp_data2_reg;
    logic [31:0]        mem_address1_reg;
    logic [31:0]        mem_address2_reg;
    logic [31:0]        mem_write_data_reg;
    logic [1:0]         mem_read_reg;
    logic               mem_write_reg;
    logic               req_fault;

    mem_addr_check #(
        .DATA_LIMIT(DATA_LIMIT)
    ) u_check (
        .op    (bus.req_op),
        .addr1 (bus.req_addr1),
        .addr2 (bus.req_addr2),
        .fault (req_fault)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= S_IDLE;
            op_reg             <= OP_ILLEGAL;
            fault_reg          <= 1'b0;
            req_ready_reg      <= 1'b1;
            rsp_valid_reg      <= 1'b0;
            rsp_fault_reg      <= 1'b0;
            rsp_data1_reg      <= '0;
            rsp_data2_reg      <= '0;
            mem_address1_reg   <= '0;
            mem_address2_reg   <= '0;
            mem_write_data_reg <= '0;
            mem_read_reg       <= 2'd0;
            mem_write_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        op_reg        <= bus.req_op;
                        fault_reg     <= req_fault;
                        req_ready_reg <= 1'b0;
                        rsp_fault_reg <= 1'b0;
                        rsp_data1_reg <= '0;
                        rsp_data2_reg <= '0;
                        state_reg     <= S_ISSUE;
                        // Strobes are registered here so they are live for the whole ISSUE cycle.
                        if (!req_fault) begin
                            mem_address1_reg   <= bus.req_addr1;
                            mem_address2_reg   <= bus.req_addr2;
                            mem_write_data_reg <= bus.req_wdata;
                            mem_read_reg       <= read_code(bus.req_op);
                            mem_write_reg      <= (bus.req_op == OP_STORE);
                        end
                    end
                end
                S_ISSUE: begin
                    mem_read_reg  <= 2'd0;
                    mem_write_reg <= 1'b0;
                    // A faulted request also spends this cycle here, but with no strobes.
                    if (fault_reg || (op_reg == OP_STORE)) begin
                        rsp_fault_reg <= fault_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    rsp_data1_reg <= bus.mem_data1;
                    rsp_data2_reg <= (op_reg == OP_LOAD2) ? bus.mem_data2 : 32'sd0;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_fault_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_reg;
    assign bus.rsp_valid      = rsp_valid_reg;
    assign bus.rsp_fault      = rsp_fault_reg;
    assign bus.rsp_data1      = rsp_data1_reg;
    assign bus.rsp_data2      = rsp_data2_reg;
    assign bus.mem_address1   = mem_address1_reg;
    assign bus.mem_address2   = mem_address2_reg;
    assign bus.mem_write_data = mem_write_data_reg;
    assign bus.mem_read       = mem_read_reg;
    assign bus.mem_write      = mem_write_reg;
    assign bus.mem_en         = ~reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed scenarios plus random requests against a rule-level reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam logic [31:0] LIMIT = 32'd1048576;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;
    int   txn_cnt;

    logic [31:0] mem_model [int unsigned];
    logic [31:0] ref_mem   [int unsigned];

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'd0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    // Behavioural data memory with one-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_write) mem_model[bus.mem_address1] = bus.mem_write_data;
            if (bus.mem_read != 2'd0) bus.mem_data1 <= mem_rd(bus.mem_address1);
            if (bus.mem_read == 2'd2) bus.mem_data2 <= mem_rd(bus.mem_address2);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem_model[a] = d;
        ref_mem[a]   = d;
    endtask

    // Issue one request, follow it to its response and release it after 'stall' cycles of backpressure.
    task automatic do_req(input logic [1:0] op, input logic [31:0] a1, input logic [31:0] a2,
                          input logic [31:0] wd, input int stall);
        logic        legal;
        logic [1:0]  exp_rd;
        logic        exp_wr;
        int          exp_lat;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
        logic [1:0]  first_rd;
        logic        first_wr;
        logic [31:0] first_a1;
        logic [31:0] first_wd;
        logic        extra_strobe;
        int          lat;
        logic        hold_ok;
        logic [31:0] snap_d1;
        logic [31:0] snap_d2;
        logic        snap_f;

        legal   = (op != 2'd0) && (a1 < LIMIT) && ((op != 2'd2) || (a2 < LIMIT));
        exp_rd  = !legal ? 2'd0 : (op == 2'd1) ? 2'd1 : (op == 2'd2) ? 2'd2 : 2'd0;
        exp_wr  = legal && (op == 2'd3);
        exp_lat = (legal && (op == 2'd1 || op == 2'd2)) ? 2 : 1;
        exp_d1  = (legal && (op == 2'd1 || op == 2'd2)) ? ref_rd(a1) : 32'd0;
        exp_d2  = (legal && (op == 2'd2)) ? ref_rd(a2) : 32'd0;
        if (exp_wr) ref_mem[a1] = wd;

        chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr1 = a1;
        bus.req_addr2 = a2;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        first_rd = bus.mem_read;
        first_wr = bus.mem_write;
        first_a1 = bus.mem_address1;
        first_wd = bus.mem_write_data;
        chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
        chk("issue_read", {62'd0, first_rd}, {62'd0, exp_rd});
        chk("issue_write", {63'd0, first_wr}, {63'd0, exp_wr});
        if (legal) chk("issue_addr1", {32'd0, first_a1}, {32'd0, a1});
        if (exp_wr) chk("issue_wdata", {32'd0, first_wd}, {32'd0, wd});

        lat = 0;
        extra_strobe = 1'b0;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.rsp_valid) break;
            if (bus.mem_read != 2'd0 || bus.mem_write) extra_strobe = 1'b1;
        end
        chk("rsp_latency", 64'(lat), 64'(exp_lat));
        chk("late_strobe", {63'd0, extra_strobe}, 64'd0);
        chk("rsp_fault", {63'd0, bus.rsp_fault}, {63'd0, !legal});
        chk("rsp_data1", {32'd0, bus.rsp_data1}, {32'd0, exp_d1});
        chk("rsp_data2", {32'd0, bus.rsp_data2}, {32'd0, exp_d2});
        $display("txn %0d op=%0d a1=%h a2=%h wd=%h -> lat=%0d fault=%0d d1=%h d2=%h",
                 txn_cnt, op, a1, a2, wd, lat, bus.rsp_fault, bus.rsp_data1, bus.rsp_data2);
        txn_cnt++;

        snap_d1 = bus.rsp_data1;
        snap_d2 = bus.rsp_data2;
        snap_f  = bus.rsp_fault;
        hold_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            if (!bus.rsp_valid || bus.req_ready || bus.rsp_data1 !== snap_d1 ||
                bus.rsp_data2 !== snap_d2 || bus.rsp_fault !== snap_f || bus.mem_read != 2'd0 ||
                bus.mem_write) hold_ok = 1'b0;
        end
        if (stall > 0) chk("rsp_hold", {63'd0, hold_ok}, 64'd1);

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_release", {63'd0, bus.rsp_valid}, 64'd0);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 32'($urandom_range(0, 31));
        if (r == 8) return LIMIT - 32'd1;
        case ($urandom_range(0, 3))
            0:       return LIMIT;
            1:       return LIMIT + 32'd1;
            2:       return 32'hFFFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    initial begin
        int lat_seen;
        vec_cnt = 0;
        err_cnt = 0;
        txn_cnt = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr1 = '0;
        bus.req_addr2 = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.mem_data1 = '0;
        bus.mem_data2 = '0;

        for (int a = 0; a < 32; a++) preload(32'(a), $urandom);
        preload(LIMIT - 32'd1, 32'hCAFE_F00D);
        preload(32'd5, 32'hDEAD_BEEF);
        preload(32'd3, 32'hFFFF_FFFF);
        preload(32'd4, 32'd7);

        // A request presented during reset must not be taken.
        repeat (2) @(posedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LOAD;
        bus.req_addr1 = 32'd5;
        @(posedge clk);
        #1;
        chk("reset_mem_en", {63'd0, bus.mem_en}, 64'd0);
        chk("reset_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("reset_rsp_fault", {63'd0, bus.rsp_fault}, 64'd0);
        chk("reset_rsp_data", {bus.rsp_data1, bus.rsp_data2}, 64'd0);
        chk("reset_strobes", {61'd0, bus.mem_read, bus.mem_write}, 64'd0);
        chk("reset_addr", {bus.mem_address1, bus.mem_address2}, 64'd0);
        chk("reset_wdata", {32'd0, bus.mem_write_data}, 64'd0);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("run_mem_en", {63'd0, bus.mem_en}, 64'd1);
        chk("no_accept_in_reset", {61'd0, bus.mem_read, bus.req_ready}, 64'd1);

        do_req(OP_LOAD,    32'd5,  32'd0,       32'd0,        0);
        do_req(OP_STORE,   32'd10, 32'd0,       32'h1234_5678, 0);
        do_req(OP_LOAD,    32'd10, 32'd0,       32'd0,        0);
        do_req(OP_LOAD2,   32'd3,  32'd4,       32'd0,        0);
        do_req(OP_LOAD2,   32'd1,  LIMIT,       32'd0,        0);
        do_req(OP_ILLEGAL, 32'd2,  32'd2,       32'd0,        0);
        do_req(OP_STORE,   LIMIT,  32'd0,       32'h5555_AAAA, 0);
        do_req(OP_LOAD,    LIMIT - 32'd1, 32'd0, 32'd0,       0);
        do_req(OP_LOAD,    32'd5,  32'd0,       32'd0,        5);
        chk("mem_not_written_oob", {32'd0, mem_rd(LIMIT)}, 64'd0);

        // Reset while the load is in WAIT must abort it silently.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LOAD;
        bus.req_addr1 = 32'd5;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_mem_en", {63'd0, bus.mem_en}, 64'd0);
        reset = 1'b0;
        chk("abort_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("abort_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        lat_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) lat_seen++;
        end
        chk("abort_no_rsp", 64'(lat_seen), 64'd0);

        for (int t = 0; t < 60; t++) begin
            do_req(2'($urandom_range(0, 3)), pick_addr(), pick_addr(), $urandom,
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
